// File: rtl/load_writeback_unit_pkg.sv
// Shared definitions for the load/writeback path.
//   F3_*         load funct3 encodings understood by the unit
//   lwu_state_t  control states of load_writeback_unit
package rv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WB,
      S_DRAIN,
      S_ERR
   } lwu_state_t;

endpackage

// File: rtl/load_writeback_unit_if.sv
// Data-memory read port used by the load unit.
//   req     request valid, held until gnt
//   addr    word-aligned read address, stable while req is high
//   gnt     request accepted this cycle
//   rvalid  read data valid (earliest the cycle after gnt)
//   rdata   read word
// master = load unit side, slave = memory side.
interface lwu_dmem_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_writeback_unit_align.sv
// load_align: combinational load data alignment and legality check.
//   funct3      load type
//   addr_lo     byte offset within the word
//   rdata       word returned by memory
//   wdata       shifted and sign/zero-extended load value
//   misaligned  illegal funct3 or offset not allowed for the access size
module load_align
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] wdata,
   output logic            misaligned
);

   // Only the low halfword of the shifted word is ever used; LW takes rdata directly.
   logic [15:0] sh;
   assign sh = 16'(rdata >> {addr_lo, 3'b000});

   always_comb begin
      // NOTE: both outputs get a default before the case so no path leaves them unassigned, which would infer a latch.
      wdata      = '0;
      misaligned = 1'b0;
      case (funct3)
         F3_LB:  wdata = {{(XLEN-8){sh[7]}}, sh[7:0]};
         F3_LBU: wdata = {{(XLEN-8){1'b0}}, sh[7:0]};
         F3_LH: begin
            wdata      = {{(XLEN-16){sh[15]}}, sh};
            misaligned = addr_lo[0];
         end
         F3_LHU: begin
            wdata      = {{(XLEN-16){1'b0}}, sh};
            misaligned = addr_lo[0];
         end
         F3_LW: begin
            wdata      = rdata;
            misaligned = (addr_lo != 2'b00);
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/load_writeback_unit.sv
// load_writeback_unit: issues one data-memory read per load, aligns and
// extends the returned word and writes it to the register file.
//   clk, rst_n             clock, asynchronous active-low reset
//   ld_valid/ld_ready      load request handshake (ready only when idle)
//   ld_funct3/addr/rd      load type, byte address, destination register
//   flush                  abandon the in-flight load
//   dmem                   memory read port (req/addr/gnt/rvalid/rdata)
//   rf_we/rf_rd/rf_wdata   register file write port (rd/wdata hold when idle)
//   ld_done                pulse: load retired (written, or rd==0)
//   ld_err                 pulse: misaligned or illegal load, nothing written
module load_writeback_unit
   import rv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [2:0]        ld_funct3,
   input  logic [XLEN-1:0]   ld_addr,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic              flush,
   lwu_dmem_if.master        dmem,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_rd,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              ld_done,
   output logic              ld_err
);

   lwu_state_t        state;
   logic [2:0]        f3_q;
   logic [1:0]        addr_lo_q;
   logic [REG_AW-1:0] rd_q;

   logic [2:0]        align_f3;
   logic [1:0]        align_lo;
   logic [XLEN-1:0]   align_wdata;
   logic              align_bad;

   assign ld_ready = (state == S_IDLE);

   // One aligner serves both jobs: while idle it vets the incoming request,
   // afterwards it aligns the returned word using the latched fields.
   assign align_f3 = ld_ready ? ld_funct3    : f3_q;
   assign align_lo = ld_ready ? ld_addr[1:0] : addr_lo_q;

   load_align #(.XLEN(XLEN)) u_align (
      .funct3     (align_f3),
      .addr_lo    (align_lo),
      .rdata      (dmem.rdata),
      .wdata      (align_wdata),
      .misaligned (align_bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         f3_q      <= '0;
         addr_lo_q <= '0;
         rd_q      <= '0;
         dmem.req  <= 1'b0;
         dmem.addr <= '0;
         rf_we     <= 1'b0;
         rf_rd     <= '0;
         rf_wdata  <= '0;
         ld_done   <= 1'b0;
         ld_err    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so every branch sees the pre-edge state.
         rf_we   <= 1'b0;
         ld_done <= 1'b0;
         ld_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ld_valid) begin
                  f3_q      <= ld_funct3;
                  addr_lo_q <= ld_addr[1:0];
                  rd_q      <= ld_rd;
                  if (align_bad) begin
                     state  <= S_ERR;
                     ld_err <= 1'b1;
                  end else begin
                     state     <= S_REQ;
                     dmem.req  <= 1'b1;
                     dmem.addr <= {ld_addr[XLEN-1:2], 2'b00};
                  end
               end
            end
            S_ERR: state <= S_IDLE;
            S_REQ: begin
               if (dmem.gnt) begin
                  // A flush racing the grant still owes memory one response.
                  dmem.req <= 1'b0;
                  state    <= flush ? S_DRAIN : S_WAIT;
               end else if (flush) begin
                  dmem.req <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (flush) begin
                  state <= dmem.rvalid ? S_IDLE : S_DRAIN;
               end else if (dmem.rvalid) begin
                  state   <= S_WB;
                  ld_done <= 1'b1;
                  // rd==0 retires without touching the write port values.
                  if (rd_q != '0) begin
                     rf_we    <= 1'b1;
                     rf_rd    <= rd_q;
                     rf_wdata <= align_wdata;
                  end
               end
            end
            S_DRAIN: if (dmem.rvalid) state <= S_IDLE;
            S_WB:    state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: a transaction-level model
// plans each load's cycle-by-cycle timeline into expectation tables, and one
// compare process checks every DUT output against those tables each cycle.
module tb_load_writeback_unit;
   import rv_pkg::*;

   localparam int MAXC = 8000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  ld_funct3;
   logic [31:0] ld_addr;
   logic [4:0]  ld_rd;
   logic        flush;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic        ld_done;
   logic        ld_err;

   lwu_dmem_if #(.XLEN(32)) dmem ();

   load_writeback_unit #(.XLEN(32), .REG_AW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_funct3 (ld_funct3),
      .ld_addr   (ld_addr),
      .ld_rd     (ld_rd),
      .flush     (flush),
      .dmem      (dmem.master),
      .rf_we     (rf_we),
      .rf_rd     (rf_rd),
      .rf_wdata  (rf_wdata),
      .ld_done   (ld_done),
      .ld_err    (ld_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected outputs per cycle number.
   bit          exp_ready [MAXC];
   bit          exp_req   [MAXC];
   bit          exp_we    [MAXC];
   bit          exp_done  [MAXC];
   bit          exp_err   [MAXC];
   bit          exp_wr    [MAXC];
   logic [31:0] exp_addr  [MAXC];
   logic [4:0]  wr_rd     [MAXC];
   logic [31:0] wr_data   [MAXC];

   bit          cmp_en = 1'b0;
   logic [4:0]  last_rd;
   logic [31:0] last_wdata;
   int          obs_we_cyc, obs_done_cyc, obs_err_cyc;
   logic [31:0] obs_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   function automatic bit model_illegal(input logic [2:0] f3, input logic [31:0] addr);
      case (f3)
         F3_LB, F3_LBU: return 1'b0;
         F3_LH, F3_LHU: return addr[0];
         F3_LW:         return addr[1:0] != 2'b00;
         default:       return 1'b1;
      endcase
   endfunction

   // Pick the addressed byte/halfword out of the word and extend it.
   function automatic logic [31:0] model_align(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
      int          b;
      int          s;
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      b      = int'(addr[1:0]);
      byte_v = word[8*b +: 8];
      half_v = (b <= 2) ? word[8*b +: 16] : 16'h0;
      case (f3)
         F3_LB:   begin s = $signed(byte_v); return s; end
         F3_LBU:  return {24'h0, byte_v};
         F3_LH:   begin s = $signed(half_v); return s; end
         F3_LHU:  return {16'h0, half_v};
         default: return word;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ld_valid    = 1'b0;
      ld_funct3   = '0;
      ld_addr     = '0;
      ld_rd       = '0;
      flush       = 1'b0;
      dmem.gnt    = 1'b0;
      dmem.rvalid = 1'b0;
      dmem.rdata  = '0;
   endtask

   // Issue one load in the current (idle) cycle c0 and play out the memory
   // side. g = cycles of gnt delay, r = cycles from WAIT entry to rvalid.
   // fmode 0: no flush, 1: flush in REQ fpos cycles in (gnt withheld),
   // 2: flush in WAIT fpos cycles in (fpos==r means same cycle as rvalid).
   // wb_flush raises flush in the writeback cycle, which must be ignored.
   // Returns in the first cycle the unit is idle again.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] data, input int g, input int r,
                          input int fmode, input int fpos, input bit wb_flush);
      int c0, cg, cr, cf, c_end, c_req_last;
      bit bad;
      c0  = cyc;
      bad = model_illegal(f3, addr);
      cg  = c0 + 1 + g;
      cr  = cg + 1 + r;
      cf  = -1;
      if (bad) begin
         c_end = c0 + 2;
      end else if (fmode == 1) begin
         cf    = c0 + 1 + fpos;
         c_end = cf + 1;
      end else if (fmode == 2) begin
         cf    = cg + 1 + fpos;
         c_end = cr + 1;
      end else begin
         c_end = cr + 2;
         if (wb_flush) cf = cr + 1;
      end

      for (int c = c0 + 1; c < c_end; c++) exp_ready[c] = 1'b0;
      if (bad) begin
         exp_err[c0 + 1] = 1'b1;
      end else begin
         c_req_last = (fmode == 1) ? cf : cg;
         for (int c = c0 + 1; c <= c_req_last; c++) begin
            exp_req[c]  = 1'b1;
            exp_addr[c] = {addr[31:2], 2'b00};
         end
         if (fmode == 0) begin
            exp_done[cr + 1] = 1'b1;
            if (rd != 5'd0) begin
               exp_we[cr + 1]  = 1'b1;
               exp_wr[cr + 1]  = 1'b1;
               wr_rd[cr + 1]   = rd;
               wr_data[cr + 1] = model_align(f3, addr, data);
            end
         end
      end

      ld_valid  = 1'b1;
      ld_funct3 = f3;
      ld_addr   = addr;
      ld_rd     = rd;
      for (int c = c0 + 1; c < c_end; c++) begin
         tick();
         // Requests while busy must be ignored, so present random junk.
         ld_valid    = 1'($urandom_range(0, 1));
         ld_funct3   = 3'($urandom);
         ld_addr     = $urandom;
         ld_rd       = 5'($urandom);
         dmem.gnt    = !bad && (fmode != 1) && (c == cg);
         dmem.rvalid = !bad && (fmode != 1) && (c == cr);
         dmem.rdata  = (c == cr) ? data : $urandom;
         flush       = (c == cf);
      end
      tick();
      idle_inputs();
   endtask

   always @(negedge clk) begin
      if (cmp_en && cyc < MAXC) begin
         check("ld_ready", 32'(ld_ready), 32'(exp_ready[cyc]));
         check("dmem_req", 32'(dmem.req), 32'(exp_req[cyc]));
         check("rf_we",    32'(rf_we),    32'(exp_we[cyc]));
         check("ld_done",  32'(ld_done),  32'(exp_done[cyc]));
         check("ld_err",   32'(ld_err),   32'(exp_err[cyc]));
         if (exp_req[cyc]) check("dmem_addr", dmem.addr, exp_addr[cyc]);
         if (exp_wr[cyc]) begin
            last_rd    = wr_rd[cyc];
            last_wdata = wr_data[cyc];
         end
         check("rf_rd",    32'(rf_rd), 32'(last_rd));
         check("rf_wdata", rf_wdata, last_wdata);
         if (rf_we)   begin obs_we_cyc = cyc; obs_wdata = rf_wdata; end
         if (ld_done) obs_done_cyc = cyc;
         if (ld_err)  obs_err_cyc  = cyc;
      end
   end

   initial begin
      int c0;
      int g, r, fmode, fpos;
      logic [2:0] f3;

      for (int i = 0; i < MAXC; i++) exp_ready[i] = 1'b1;
      last_rd    = '0;
      last_wdata = '0;
      rst_n      = 1'b0;
      idle_inputs();
      repeat (3) tick();

      check("rst_ld_ready",  32'(ld_ready), 32'd1);
      check("rst_dmem_req",  32'(dmem.req), 32'd0);
      check("rst_dmem_addr", dmem.addr,     32'd0);
      check("rst_rf_we",     32'(rf_we),    32'd0);
      check("rst_rf_rd",     32'(rf_rd),    32'd0);
      check("rst_rf_wdata",  rf_wdata,      32'd0);
      check("rst_ld_done",   32'(ld_done),  32'd0);
      check("rst_ld_err",    32'(ld_err),   32'd0);

      rst_n = 1'b1;
      tick();
      cmp_en = 1'b1;

      // Directed loads with hand-computed results.
      obs_we_cyc = -1;
      c0 = cyc;
      do_load(F3_LB, 32'h103, 5'd5, 32'h80FF_1234, 0, 0, 0, 0, 1'b0);
      check("lb_latency", 32'(obs_we_cyc - c0), 32'd3);
      check("lb_data",    obs_wdata, 32'hFFFF_FF80);

      do_load(F3_LHU, 32'h102, 5'd6, 32'h80FF_1234, 0, 0, 0, 0, 1'b0);
      check("lhu_data", obs_wdata, 32'h0000_80FF);
      do_load(F3_LH, 32'h102, 5'd7, 32'h80FF_1234, 0, 0, 0, 0, 1'b0);
      check("lh_data", obs_wdata, 32'hFFFF_80FF);
      do_load(F3_LW, 32'h100, 5'd8, 32'h80FF_1234, 0, 0, 0, 0, 1'b0);
      check("lw_data", obs_wdata, 32'h80FF_1234);

      c0 = cyc;
      do_load(F3_LW, 32'h101, 5'd9, 32'h1111_2222, 0, 0, 0, 0, 1'b0);
      check("lw_misaligned_err_cycle", 32'(obs_err_cyc - c0), 32'd1);

      obs_we_cyc = -1;
      c0 = cyc;
      do_load(F3_LW, 32'h200, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 1'b0);
      check("rd0_done_cycle", 32'(obs_done_cyc - c0), 32'd3);
      check("rd0_no_write",   32'(obs_we_cyc), 32'hFFFF_FFFF);

      c0 = cyc;
      do_load(F3_LW, 32'h2004, 5'd11, 32'hCAFE_F00D, 3, 0, 0, 0, 1'b0);
      check("gnt_delay_latency", 32'(obs_we_cyc - c0), 32'd6);

      obs_we_cyc = -1;
      do_load(F3_LW, 32'h300, 5'd12, 32'h5555_AAAA, 0, 2, 2, 0, 1'b0);
      check("flush_wait_no_write", 32'(obs_we_cyc), 32'hFFFF_FFFF);
      c0 = cyc;
      do_load(F3_LBU, 32'h301, 5'd13, 32'h0000_AB00, 0, 0, 0, 0, 1'b0);
      check("after_flush_latency", 32'(obs_we_cyc - c0), 32'd3);
      check("after_flush_data",    obs_wdata, 32'h0000_00AB);

      // Randomized loads, including illegal ones, stalls and flushes.
      for (int n = 0; n < 250 && cyc + 20 < MAXC; n++) begin
         f3 = 3'($urandom);
         g  = int'($urandom_range(0, 3));
         r  = int'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0, 1:    begin fmode = 1; fpos = int'($urandom_range(0, g)); end
            2, 3:    begin fmode = 2; fpos = int'($urandom_range(0, r)); end
            default: begin fmode = 0; fpos = 0; end
         endcase
         do_load(f3, $urandom, 5'($urandom), $urandom, g, r, fmode, fpos,
                 ($urandom_range(0, 4) == 0));
         repeat ($urandom_range(0, 2)) tick();
      end

      // Reset while a load waits for data: outputs clear at once, the late
      // response is ignored and nothing is written.
      cmp_en    = 1'b0;
      ld_valid  = 1'b1;
      ld_funct3 = F3_LW;
      ld_addr   = 32'h400;
      ld_rd     = 5'd3;
      tick();
      idle_inputs();
      dmem.gnt = 1'b1;
      tick();
      dmem.gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_dmem_req",  32'(dmem.req), 32'd0);
      check("midrst_dmem_addr", dmem.addr,     32'd0);
      check("midrst_rf_we",     32'(rf_we),    32'd0);
      check("midrst_rf_rd",     32'(rf_rd),    32'd0);
      check("midrst_rf_wdata",  rf_wdata,      32'd0);
      check("midrst_ld_done",   32'(ld_done),  32'd0);
      check("midrst_ld_err",    32'(ld_err),   32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      dmem.rvalid = 1'b1;
      dmem.rdata  = 32'h1234_5678;
      tick();
      dmem.rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("postrst_rf_we",    32'(rf_we),    32'd0);
         check("postrst_ld_done",  32'(ld_done),  32'd0);
         check("postrst_ld_ready", 32'(ld_ready), 32'd1);
         check("postrst_rf_wdata", rf_wdata,      32'd0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
